// File: rtl/oclib_ready_valid_pipeline_pkg.sv
// Shared types and sizing helpers for the elastic ready/valid pipeline.
package oclib_ready_valid_pipeline_pkg;

  // Occupancy of one skid stage: nothing, main register only, or main plus skid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StMain  = 2'd1,
    StBoth  = 2'd2
  } skid_state_e;

  function automatic int unsigned RvPipeCapacity(input int unsigned length,
                                                 input bit skid_buffer);
    return skid_buffer ? 2 * length : length;
  endfunction

  // A zero-length pipeline still exposes a 1-bit count tied to zero.
  function automatic int unsigned RvPipeCountWidth(input int unsigned length,
                                                   input bit skid_buffer);
    int unsigned cap;
    cap = RvPipeCapacity(length, skid_buffer);
    return (cap == 0) ? 1 : $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/oclib_ready_valid_pipeline_if.sv
// One side of a valid/ready stream: the master drives data/valid, the slave drives ready.
interface oclib_ready_valid_pipeline_if #(
  parameter int unsigned Width = 1
) ();

  logic [Width-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/oclib_ready_valid_pipeline_slice.sv
// One pipeline stage: a plain register stage, or a 2-entry skid stage with registered ready.
module oclib_ready_valid_pipeline_slice
  import oclib_ready_valid_pipeline_pkg::*;
#(
  parameter int unsigned Width      = 1,
  parameter bit          SkidBuffer = 1'b0,
  parameter bit          DontTouch  = 1'b0
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned RegWidth = SkidBuffer ? 2 * Width + 3 : Width + 1;

  // All stage state lives in one vector so the keep attributes apply in a single place.
  logic [RegWidth-1:0] regs_q, regs_d;

  if (DontTouch) begin : g_keep
    (* shreg_extract = "false", dont_touch = "true" *) logic [RegWidth-1:0] r_q;
    always_ff @(posedge clock) begin
      r_q <= regs_d;
    end
    assign regs_q = r_q;
  end else begin : g_free
    (* shreg_extract = "false", dont_touch = "false" *) logic [RegWidth-1:0] r_q;
    always_ff @(posedge clock) begin
      r_q <= regs_d;
    end
    assign regs_q = r_q;
  end

  if (SkidBuffer) begin : g_skid
    skid_state_e      state_q, state_d;
    logic             ready_q;
    logic             in_xfer;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;

    assign main_q  = regs_q[Width-1:0];
    assign skid_q  = regs_q[2*Width-1:Width];
    assign state_q = skid_state_e'(regs_q[2*Width+1:2*Width]);
    assign ready_q = regs_q[2*Width+2];
    assign in_xfer = in_valid && ready_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StMain;
            main_d  = in_data;
          end
        end
        StMain: begin
          if (out_ready) begin
            if (in_xfer) main_d = in_data;
            else         state_d = StEmpty;
          end else if (in_xfer) begin
            // Downstream stalled: park the new beat behind the held one.
            state_d = StBoth;
            skid_d  = in_data;
          end
        end
        StBoth: begin
          // Ready is low here, so only the skid can refill main.
          if (out_ready) begin
            state_d = StMain;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
      if (!resetN) state_d = StEmpty;
      regs_d = {(resetN && (state_d != StBoth)), state_d, skid_d, main_d};
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
  end else begin : g_plain
    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign valid_q  = regs_q[Width];
    assign data_q   = regs_q[Width-1:0];
    assign in_ready = !valid_q || out_ready;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) begin
        valid_d = in_valid;
        if (in_valid) data_d = in_data;
      end
      if (!resetN) valid_d = 1'b0;
      regs_d = {valid_d, data_d};
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
  end

endmodule

// File: rtl/oclib_ready_valid_pipeline.sv
// Elastic ready/valid retiming pipeline: a chain of Length stages plus an occupancy counter.
module oclib_ready_valid_pipeline
  import oclib_ready_valid_pipeline_pkg::*;
#(
  parameter int unsigned Width      = 1,
  parameter int unsigned Length     = 1,
  parameter bit          SkidBuffer = 1'b0,
  parameter bit          DontTouch  = 1'b0,
  localparam int unsigned CountWidth = RvPipeCountWidth(Length, SkidBuffer)
) (
  input  logic                        clock,
  input  logic                        resetN,
  oclib_ready_valid_pipeline_if.slave  in_rv,
  oclib_ready_valid_pipeline_if.master out_rv,
  output logic [CountWidth-1:0]       count
);

  if (Length == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ resetN;

    assign out_rv.data  = in_rv.data;
    assign out_rv.valid = in_rv.valid;
    assign in_rv.ready  = out_rv.ready;
    assign count        = '0;
  end else begin : g_pipe
    logic [Width-1:0]      data_s  [Length+1];
    logic                  valid_s [Length+1];
    logic                  ready_s [Length+1];
    logic                  in_xfer, out_xfer;
    logic [CountWidth-1:0] count_q;

    assign data_s[0]  = in_rv.data;
    assign valid_s[0] = in_rv.valid;
    // Both ends are masked during reset so nothing transfers until stages are cleared.
    assign in_rv.ready  = resetN && ready_s[0];
    assign out_rv.valid = resetN && valid_s[Length];
    assign out_rv.data  = data_s[Length];
    assign ready_s[Length] = out_rv.ready;

    for (genvar i = 0; i < Length; i++) begin : g_stage
      oclib_ready_valid_pipeline_slice #(
        .Width      (Width),
        .SkidBuffer (SkidBuffer),
        .DontTouch  (DontTouch)
      ) u_slice (
        .clock     (clock),
        .resetN    (resetN),
        .in_data   (data_s[i]),
        .in_valid  (valid_s[i]),
        .in_ready  (ready_s[i]),
        .out_data  (data_s[i+1]),
        .out_valid (valid_s[i+1]),
        .out_ready (ready_s[i+1])
      );
    end

    assign in_xfer  = in_rv.valid && in_rv.ready;
    assign out_xfer = out_rv.valid && out_rv.ready;

    always_ff @(posedge clock) begin
      if (!resetN) begin
        count_q <= '0;
      end else if (in_xfer && !out_xfer) begin
        count_q <= count_q + CountWidth'(1);
      end else if (!in_xfer && out_xfer) begin
        count_q <= count_q - CountWidth'(1);
      end
    end

    assign count = count_q;
  end

endmodule

// File: tb/tb_oclib_ready_valid_pipeline.sv
// Directed and random scoreboard checks across plain, skid and passthrough pipelines.
module tb_oclib_ready_valid_pipeline;

  localparam int NumDut = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] in_data   [NumDut];
  logic       in_valid  [NumDut];
  logic       in_ready  [NumDut];
  logic [7:0] out_data  [NumDut];
  logic       out_valid [NumDut];
  logic       out_ready [NumDut];
  logic [7:0] cnt       [NumDut];

  oclib_ready_valid_pipeline_if #(.Width(8)) in_if  [NumDut] ();
  oclib_ready_valid_pipeline_if #(.Width(8)) out_if [NumDut] ();

  for (genvar k = 0; k < NumDut; k++) begin : g_conn
    assign in_if[k].data   = in_data[k];
    assign in_if[k].valid  = in_valid[k];
    assign in_ready[k]     = in_if[k].ready;
    assign out_data[k]     = out_if[k].data;
    assign out_valid[k]    = out_if[k].valid;
    assign out_if[k].ready = out_ready[k];
  end

  logic [1:0] c0;
  logic [2:0] c1, c2;
  logic [3:0] c3;
  logic       c4;
  assign cnt[0] = 8'(c0);
  assign cnt[1] = 8'(c1);
  assign cnt[2] = 8'(c2);
  assign cnt[3] = 8'(c3);
  assign cnt[4] = 8'(c4);

  oclib_ready_valid_pipeline #(.Width(8), .Length(3), .SkidBuffer(1'b0)) u_dut0 (
    .clock(clk), .resetN(rst_n), .in_rv(in_if[0]), .out_rv(out_if[0]), .count(c0));
  oclib_ready_valid_pipeline #(.Width(8), .Length(2), .SkidBuffer(1'b1)) u_dut1 (
    .clock(clk), .resetN(rst_n), .in_rv(in_if[1]), .out_rv(out_if[1]), .count(c1));
  oclib_ready_valid_pipeline #(.Width(8), .Length(4), .SkidBuffer(1'b0)) u_dut2 (
    .clock(clk), .resetN(rst_n), .in_rv(in_if[2]), .out_rv(out_if[2]), .count(c2));
  oclib_ready_valid_pipeline #(.Width(8), .Length(4), .SkidBuffer(1'b1), .DontTouch(1'b1))
    u_dut3 (.clock(clk), .resetN(rst_n), .in_rv(in_if[3]), .out_rv(out_if[3]), .count(c3));
  oclib_ready_valid_pipeline #(.Width(8), .Length(0), .SkidBuffer(1'b0)) u_dut4 (
    .clock(clk), .resetN(rst_n), .in_rv(in_if[4]), .out_rv(out_if[4]), .count(c4));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int acc_cyc[$];
  int out_cyc[$];
  int n_acc, n_out, cnt_max, low_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    sb.delete();
    acc_cyc.delete();
    out_cyc.delete();
    n_acc = 0;
    n_out = 0;
    cnt_max = 0;
  endtask

  // Settle inputs, score this cycle's transfers on DUT k, then advance one clock.
  task automatic tick(input int k, input bit chk_cnt);
    logic in_x, out_x;
    logic [7:0] exp;
    #1;
    in_x  = in_valid[k] && in_ready[k];
    out_x = out_valid[k] && out_ready[k];
    if (chk_cnt) check("count_vs_scoreboard", 32'(cnt[k]), 32'(sb.size()));
    if (int'(cnt[k]) > cnt_max) cnt_max = int'(cnt[k]);
    if (out_x) begin
      check("beat_available", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("beat_order", 32'(out_data[k]), 32'(exp));
      end
      n_out++;
      out_cyc.push_back(cyc);
    end
    if (in_x) begin
      sb.push_back(in_data[k]);
      acc_cyc.push_back(cyc);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < NumDut; k++) begin
      in_data[k] = '0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    clear_sb();
    low_cyc = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    for (int k = 0; k < 4; k++) begin
      check("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check("rst_count", 32'(cnt[k]), 32'd0);
      check("rst_in_ready", 32'(in_ready[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_plain_ready", 32'(in_ready[0]), 32'd1);
    check("post_rst_skid_ready", 32'(in_ready[1]), 32'd1);

    // 1: Length 3 plain, free-flowing output
    clear_sb();
    out_ready[0] = 1'b1;
    for (int t = 0; t < 20 && n_acc < 5; t++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h11 + 8'(n_acc);
      tick(0, 1'b1);
    end
    in_valid[0] = 1'b0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) tick(0, 1'b1);
    check("t1_drained", 32'(sb.size()), 32'd0);
    check("t1_beats_out", 32'(n_out), 32'd5);
    check("t1_latency", 32'(out_cyc[0] - acc_cyc[0]), 32'd3);
    check("t1_in_rate", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
    check("t1_out_rate", 32'(out_cyc[4] - out_cyc[0]), 32'd4);
    check("t1_count_max", 32'(cnt_max), 32'd3);

    // 2: Length 3 plain, stalled output fills to capacity
    clear_sb();
    out_ready[0] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h21 + 8'(n_acc);
      tick(0, 1'b1);
    end
    #1;
    check("t2_accepted", 32'(n_acc), 32'd3);
    check("t2_count_full", 32'(cnt[0]), 32'd3);
    check("t2_ready_full", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    for (int t = 0; t < 20 && n_acc < 4; t++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h21 + 8'(n_acc);
      tick(0, 1'b1);
    end
    in_valid[0] = 1'b0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) tick(0, 1'b1);
    check("t2_beats_out", 32'(n_out), 32'd4);
    check("t2_drained", 32'(sb.size()), 32'd0);

    // 3: Length 2 skid, stalled output, registered ready
    clear_sb();
    out_ready[1] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 8'h31 + 8'(n_acc);
      #1;
      if (!in_ready[1] && low_cyc < 0) low_cyc = cyc;
      tick(1, 1'b1);
    end
    check("t3_accepted", 32'(n_acc), 32'd4);
    check("t3_count_full", 32'(cnt[1]), 32'd4);
    check("t3_ready_fall", 32'(low_cyc), 32'(acc_cyc[3] + 1));
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    #1;
    check("t3_ready_not_comb", 32'(in_ready[1]), 32'd0);
    for (int t = 0; t < 20 && sb.size() > 0; t++) tick(1, 1'b1);
    check("t3_beats_out", 32'(n_out), 32'd4);
    check("t3_drained", 32'(sb.size()), 32'd0);

    // 4: Length 4 plain and skid under random valid/ready
    for (int k = 2; k <= 3; k++) begin
      clear_sb();
      for (int t = 0; t < 30000 && n_acc < 3000; t++) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        in_data[k]   = 8'($urandom);
        out_ready[k] = 1'($urandom_range(0, 1));
        tick(k, 1'b1);
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      for (int t = 0; t < 50 && sb.size() > 0; t++) tick(k, 1'b1);
      check("t4_accepted", 32'(n_acc), 32'd3000);
      check("t4_beats_out", 32'(n_out), 32'd3000);
      check("t4_drained", 32'(sb.size()), 32'd0);
    end

    // 5: reset with beats in flight discards them
    clear_sb();
    out_ready[0] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h51 + 8'(n_acc);
      tick(0, 1'b1);
    end
    check("t5_count_full", 32'(cnt[0]), 32'd3);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_ready_in_reset", 32'(in_ready[0]), 32'd0);
    check("t5_valid_in_reset", 32'(out_valid[0]), 32'd0);
    tick(0, 1'b0);
    rst_n = 1'b1;
    clear_sb();
    #1;
    check("t5_count_cleared", 32'(cnt[0]), 32'd0);
    check("t5_valid_cleared", 32'(out_valid[0]), 32'd0);
    for (int t = 0; t < 8; t++) tick(0, 1'b1);
    check("t5_no_stale_beat", 32'(n_out), 32'd0);

    // 6: Length 0 passthrough
    for (int i = 0; i < 8; i++) begin
      in_valid[4]  = i[0];
      out_ready[4] = i[1];
      in_data[4]   = 8'($urandom);
      #1;
      check("t6_valid_pass", 32'(out_valid[4]), 32'(in_valid[4]));
      check("t6_ready_pass", 32'(in_ready[4]), 32'(out_ready[4]));
      check("t6_data_pass", 32'(out_data[4]), 32'(in_data[4]));
      check("t6_count_zero", 32'(cnt[4]), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
